// File: rtl/manchester_pkg.sv
// Shared types and timing constants for the Manchester receiver.
package manchester_pkg;

    localparam int unsigned OVS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RECV  = 2'd2
    } rx_state_t;

    // Earliest elapsed count at which an edge is accepted as a mid-bit edge.
    function automatic int unsigned win_lo(input int unsigned ovs);
        return (3 * ovs) / 4;
    endfunction

    // Latest elapsed count at which an edge is accepted as a mid-bit edge.
    function automatic int unsigned win_hi(input int unsigned ovs);
        return (5 * ovs) / 4;
    endfunction

    localparam int unsigned WIN_LO = win_lo(OVS_DEFAULT);
    localparam int unsigned WIN_HI = win_hi(OVS_DEFAULT);

endpackage

// File: rtl/manchester_sync_edge.sv
// Two-flop synchronizer for the raw line plus registered rise/fall pulses.
module manchester_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Synchronize the line and compare against its previous synchronized value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            line_s <= 1'b0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= line_in;
            line_s <= meta;
            prev   <= line_s;
            rise   <= line_s & ~prev;
            fall   <= ~line_s & prev;
        end
    end

endmodule

// File: rtl/manchester_rx.sv
// Manchester byte receiver: idle detection, mid-bit decode window, output stage.
module manchester_rx
    import manchester_pkg::*;
#(
    parameter int unsigned OVS = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    input  logic       en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       overrun,
    input  logic       clr_ovr
);

    localparam int unsigned LO_LIM = win_lo(OVS);
    localparam int unsigned HI_LIM = win_hi(OVS);
    localparam int unsigned TW     = $clog2(HI_LIM + 2);
    localparam int unsigned LW     = $clog2(OVS + 1);

    logic            line_s;
    logic            rise;
    logic            fall;

    rx_state_t       state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [TW-1:0]   elapsed;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shreg, shreg_n;
    logic [LW-1:0]   lowcnt, lowcnt_n;
    logic            err_n;
    logic            byte_done_c;
    logic            drop_c;

    manchester_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (line_in),
        .line_s  (line_s),
        .rise    (rise),
        .fall    (fall)
    );

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            lowcnt <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            lowcnt <= lowcnt_n;
            err    <= err_n;
        end
    end

    // Next-state decode; elapsed is the edge spacing seen in the consuming cycle.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        bitcnt_n    = bitcnt;
        shreg_n     = shreg;
        lowcnt_n    = lowcnt;
        err_n       = 1'b0;
        byte_done_c = 1'b0;
        elapsed     = timer + TW'(1);

        if (!en) begin
            state_n  = IDLE;
            lowcnt_n = '0;
            timer_n  = '0;
            bitcnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_s) begin
                        lowcnt_n = '0;
                    end else if (lowcnt == LW'(OVS - 1)) begin
                        lowcnt_n = '0;
                        state_n  = ARMED;
                    end else begin
                        lowcnt_n = lowcnt + LW'(1);
                    end
                end
                ARMED: begin
                    if (rise) begin
                        state_n  = RECV;
                        timer_n  = '0;
                        bitcnt_n = '0;
                    end else if (fall) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end
                RECV: begin
                    if ((rise || fall) && (elapsed >= TW'(LO_LIM)) && (elapsed <= TW'(HI_LIM))) begin
                        shreg_n  = {rise, shreg[7:1]};
                        timer_n  = '0;
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state_n     = IDLE;
                            bitcnt_n    = '0;
                            byte_done_c = 1'b1;
                        end
                    end else if (elapsed > TW'(HI_LIM)) begin
                        state_n  = IDLE;
                        timer_n  = '0;
                        bitcnt_n = '0;
                        err_n    = 1'b1;
                    end else begin
                        timer_n = elapsed;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign drop_c = byte_done_c && out_valid && !out_ready;

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (byte_done_c && !drop_c) begin
                out_data  <= shreg_n;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_manchester_rx.sv
// Directed self-checking bench for manchester_rx at OVS = 8.
module tb_manchester_rx;
    import manchester_pkg::*;

    logic       clk;
    logic       rst;
    logic       line_in;
    logic       en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       overrun;
    logic       clr_ovr;

    int checks;
    int errors;
    int err_cnt;
    int byte_cnt;
    logic [7:0] last_byte;

    manchester_rx #(.OVS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line_in),
        .en        (en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            byte_cnt++;
            last_byte = out_data;
        end
    end

    task automatic hold(input logic v, input int n);
        line_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit then 8 bits LSB first; sp_even/sp_odd set mid-edge spacing per data bit.
    task automatic send_frame(input logic [7:0] d, input int sp_even, input int sp_odd, input int tail);
        logic prev;
        int   sp;
        prev = 1'b1;
        hold(1'b0, 4);
        for (int i = 0; i < 8; i++) begin
            sp = ((i % 2) == 0) ? sp_even : sp_odd;
            hold(prev, sp / 2);
            hold(~d[i], sp - sp / 2);
            prev = d[i];
        end
        hold(d[7], tail);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = 1'b0; clr_ovr = 1'b0; line_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        int e0;
        out_ready = 1'b1;
        e0 = err_cnt;
        hold(1'b0, 16);
        send_frame(8'hA5, 8, 8, 3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        hold(1'b1, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", out_data); end
        hold(1'b0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", out_valid); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL single_err got %0d want %0d", err_cnt, e0); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun got %b want 0", overrun); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        hold(1'b0, 16);
        send_frame(8'h3C, 8, 8, 4);
        checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%b want 3c/1", out_data, out_valid); end
        hold(1'b0, 16);
        send_frame(8'hC3, 8, 8, 4);
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL bp_hold_data got %h want 3c", out_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
        hold(1'b0, 16);
        send_frame(8'h99, 8, 8, 3);
        clr_ovr = 1'b1;
        hold(1'b1, 1);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_set_priority got %b want 1", overrun); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL bp_hold_data2 got %h want 3c", out_data); end
        out_ready = 1'b1;
        hold(1'b0, 1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
        clr_ovr = 1'b1;
        hold(1'b0, 1);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr got %b want 0", overrun); end
    endtask

    task automatic test_code_violation();
        int e0;
        out_ready = 1'b1;
        hold(1'b0, 16);
        e0 = err_cnt;
        hold(1'b0, 4); hold(1'b1, 4);
        hold(1'b0, 4); hold(1'b1, 4);
        hold(1'b1, 4); hold(1'b0, 4);
        hold(1'b0, 4); hold(1'b1, 4);
        hold(1'b1, 12);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL cv_err got %0d want %0d", err_cnt, e0 + 1); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cv_valid got %b want 0", out_valid); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL cv_state got %0d want IDLE", dut.state); end
        hold(1'b0, 16);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL cv_err_once got %0d want %0d", err_cnt, e0 + 1); end
        send_frame(8'h55, 8, 8, 4);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL cv_next got %h/%b want 55/1", out_data, out_valid); end
        hold(1'b0, 1);
    endtask

    task automatic test_jitter();
        int e0;
        int b0;
        out_ready = 1'b1;
        hold(1'b0, 16);
        e0 = err_cnt;
        send_frame(8'hF0, 6, 10, 4);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin errors++; $display("FAIL jit_data got %h/%b want f0/1", out_data, out_valid); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL jit_noerr got %0d want %0d", err_cnt, e0); end
        hold(1'b0, 16);
        e0 = err_cnt;
        b0 = byte_cnt;
        send_frame(8'h01, 11, 8, 4);
        hold(1'b0, 16);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL jit_late_err got %0d want %0d", err_cnt, e0 + 1); end
        checks++; if (byte_cnt !== b0) begin errors++; $display("FAIL jit_late_nobyte got %0d want %0d", byte_cnt, b0); end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        out_ready = 1'b1;
        hold(1'b0, 16);
        hold(1'b0, 4); hold(1'b1, 4);
        repeat (4) begin hold(1'b0, 4); hold(1'b1, 4); end
        rst = 1'b1;
        hold(1'b0, 2);
        rst = 1'b0;
        checks++; if (dut.state !== IDLE || out_valid !== 1'b0) begin errors++; $display("FAIL rmf_reset got %0d/%b want IDLE/0", dut.state, out_valid); end
        b0 = byte_cnt;
        hold(1'b0, 16);
        send_frame(8'h81, 8, 8, 4);
        hold(1'b0, 4);
        checks++; if (byte_cnt !== b0 + 1) begin errors++; $display("FAIL rmf_count got %0d want %0d", byte_cnt, b0 + 1); end
        checks++; if (last_byte !== 8'h81) begin errors++; $display("FAIL rmf_byte got %h want 81", last_byte); end
    endtask

    task automatic test_enable();
        int e0;
        int b0;
        logic [7:0] d;
        d = 8'h5A;
        out_ready = 1'b1;
        hold(1'b0, 16);
        e0 = err_cnt;
        b0 = byte_cnt;
        hold(1'b0, 4); hold(1'b1, 4);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) en = 1'b0;
            hold(~d[i], 4);
            hold(d[i], 4);
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL en_state got %0d want IDLE", dut.state); end
        hold(1'b0, 4);
        en = 1'b1;
        hold(1'b0, 16);
        checks++; if (byte_cnt !== b0) begin errors++; $display("FAIL en_nobyte got %0d want %0d", byte_cnt, b0); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL en_noerr got %0d want %0d", err_cnt, e0); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        hold(1'b0, 16);
        send_frame(8'h11, 8, 8, 4);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL sim_first got %h/%b want 11/1", out_data, out_valid); end
        hold(1'b0, 16);
        send_frame(8'h22, 8, 8, 3);
        out_ready = 1'b1;
        hold(1'b0, 1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL sim_data got %h want 22", out_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun got %b want 0", overrun); end
        out_ready = 1'b1;
        hold(1'b0, 1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sim_drain got %b want 0", out_valid); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        err_cnt   = 0;
        byte_cnt  = 0;
        last_byte = 8'h00;
        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        line_in   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_backpressure();
        test_code_violation();
        test_jitter();
        test_reset_mid_frame();
        test_enable();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
